// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: scans two captured operands MSB-first,
// one bit per clock, stops at the first differing bit, and falls back to the
// captured cascade inputs when every bit matches. Results are one-hot
// LT/EQ/GT plus the number of bit positions examined, held until the next
// result or reset.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         START,
  input  logic [WIDTH-1:0]             A,
  input  logic [WIDTH-1:0]             B,
  input  logic                         LT_IN,
  input  logic                         EQ_IN,
  input  logic                         GT_IN,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         LT_OUT,
  output logic                         EQ_OUT,
  output logic                         GT_OUT,
  output logic [$clog2(WIDTH+1)-1:0]   BITS
);

  localparam int IDX_W  = $clog2(WIDTH);
  localparam int BITS_W = $clog2(WIDTH+1);

  // Result vectors are ordered {lt, eq, gt}
  localparam logic [2:0] RES_LT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_GT = 3'b001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [2:0]          casc_q, casc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BITS_W-1:0]   count_q, count_d;
  logic [2:0]          res_q, res_d;
  logic [BITS_W-1:0]   bits_q, bits_d;

  logic                a_bit;
  logic                b_bit;

  // Priority when all operand bits match: EQ_IN, then GT_IN, then LT_IN,
  // and EQ when nothing is asserted, so the result is always one-hot.
  function automatic logic [2:0] resolve_cascade(input logic [2:0] casc);
    logic [2:0] res;
    if (casc[1])      res = RES_EQ;
    else if (casc[0]) res = RES_GT;
    else if (casc[2]) res = RES_LT;
    else              res = RES_EQ;
    return res;
  endfunction

  // Bit pair currently under examination
  always_comb begin
    a_bit = a_q[idx_q];
    b_bit = b_q[idx_q];
  end

  // Next-state logic: capture in IDLE, one bit per cycle in SCAN,
  // publish the result on the edge into FINISH.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    casc_d  = casc_q;
    idx_d   = idx_q;
    count_d = count_q;
    res_d   = res_q;
    bits_d  = bits_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          casc_d  = {LT_IN, EQ_IN, GT_IN};
          idx_d   = IDX_W'(WIDTH-1);
          count_d = '0;
          state_d = SCAN;
        end
      end

      SCAN: begin
        count_d = count_q + BITS_W'(1);
        if (a_bit && !b_bit) begin
          res_d   = RES_GT;
          bits_d  = count_d;
          state_d = FINISH;
        end else if (!a_bit && b_bit) begin
          res_d   = RES_LT;
          bits_d  = count_d;
          state_d = FINISH;
        end else if (idx_q == '0) begin
          res_d   = resolve_cascade(casc_q);
          bits_d  = count_d;
          state_d = FINISH;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      casc_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      res_q   <= '0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      casc_q  <= casc_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      res_q   <= res_d;
      bits_q  <= bits_d;
    end
  end

  // Status and result outputs straight from registers
  always_comb begin
    BUSY   = (state_q != IDLE);
    DONE   = (state_q == FINISH);
    LT_OUT = res_q[2];
    EQ_OUT = res_q[1];
    GT_OUT = res_q[0];
    BITS   = bits_q;
  end

  // A published result is always one-hot and never wider than the operand
  always @(posedge CLK) begin
    if (RST_N && DONE) begin
      assert ($onehot(res_q));
      assert (bits_q != '0 && int'(bits_q) <= WIDTH);
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator: a cycle-level
// reference model built from plain arithmetic, a per-cycle compare process,
// directed cases with hand-computed values, and a randomized loop.
module tb_serial_magnitude_comparator;

  localparam int WIDTH  = 8;
  localparam int BITS_W = $clog2(WIDTH+1);

  logic              CLK;
  logic              RST_N;
  logic              START;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic              LT_IN;
  logic              EQ_IN;
  logic              GT_IN;
  logic              BUSY;
  logic              DONE;
  logic              LT_OUT;
  logic              EQ_OUT;
  logic              GT_OUT;
  logic [BITS_W-1:0] BITS;

  int checks   = 0;
  int failures = 0;
  bit checking = 0;

  serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .START  (START),
    .A      (A),
    .B      (B),
    .LT_IN  (LT_IN),
    .EQ_IN  (EQ_IN),
    .GT_IN  (GT_IN),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .LT_OUT (LT_OUT),
    .EQ_OUT (EQ_OUT),
    .GT_OUT (GT_OUT),
    .BITS   (BITS)
  );

  // 10-time-unit clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected {lt,eq,gt}: numeric comparison, cascade priority when equal
  function automatic logic [2:0] expectRes(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic lt, input logic eq, input logic gt);
    if (a > b) return 3'b001;
    if (a < b) return 3'b100;
    if (eq) return 3'b010;
    if (gt) return 3'b001;
    if (lt) return 3'b100;
    return 3'b010;
  endfunction

  // Positions examined: leading matching bits plus the deciding one
  function automatic int expectBits(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x;
    x = a ^ b;
    for (int i = WIDTH-1; i >= 0; i--) begin
      if (x[i]) return WIDTH - i;
    end
    return WIDTH;
  endfunction

  // Reference model: cycles remaining until the result is published
  int         mRemain   = 0;
  logic       mDone     = 1'b0;
  logic [2:0] mRes      = 3'b000;
  int         mBits     = 0;
  logic [2:0] pendRes   = 3'b000;
  int         pendBits  = 0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mRemain <= 0;
      mDone   <= 1'b0;
      mRes    <= 3'b000;
      mBits   <= 0;
    end else if (mDone) begin
      mDone <= 1'b0;
    end else if (mRemain > 0) begin
      mRemain <= mRemain - 1;
      if (mRemain == 1) begin
        mDone <= 1'b1;
        mRes  <= pendRes;
        mBits <= pendBits;
      end
    end else if (START) begin
      pendRes  <= expectRes(A, B, LT_IN, EQ_IN, GT_IN);
      pendBits <= expectBits(A, B);
      mRemain  <= expectBits(A, B);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle after reset release, outputs must track the model
  always @(negedge CLK) begin
    if (checking) begin
      checkOutput("busy",  int'(BUSY),   int'((mRemain > 0) || mDone));
      checkOutput("done",  int'(DONE),   int'(mDone));
      checkOutput("lt",    int'(LT_OUT), int'(mRes[2]));
      checkOutput("eq",    int'(EQ_OUT), int'(mRes[1]));
      checkOutput("gt",    int'(GT_OUT), int'(mRes[0]));
      checkOutput("bits",  int'(BITS),   mBits);
    end
  end

  // Present operands with START for one cycle; returns in cycle 1 after acceptance
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic lt, input logic eq, input logic gt);
    @(negedge CLK); #1;
    A = a; B = b; LT_IN = lt; EQ_IN = eq; GT_IN = gt;
    START = 1'b1;
    @(negedge CLK); #1;
    START = 1'b0;
  endtask

  // Count cycles since acceptance until DONE, optionally scrambling inputs
  task automatic waitDone(output int lat, input bit scramble);
    lat = 1;
    while (DONE !== 1'b1 && lat <= WIDTH + 4) begin
      if (scramble) begin
        A = WIDTH'($urandom);
        B = WIDTH'($urandom);
        {LT_IN, EQ_IN, GT_IN} = 3'($urandom);
      end
      @(negedge CLK); #1;
      lat++;
    end
    if (DONE !== 1'b1) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic runCase(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic lt, input logic eq, input logic gt,
                         input logic [2:0] expRes, input int expBits, input int expLat);
    int lat;
    applyStimulus(a, b, lt, eq, gt);
    waitDone(lat, 1'b1);
    checkOutput({name, "_lat"},  lat, expLat);
    checkOutput({name, "_res"},  int'({LT_OUT, EQ_OUT, GT_OUT}), int'(expRes));
    checkOutput({name, "_bits"}, int'(BITS), expBits);
  endtask

  initial begin
    int lat;
    logic [WIDTH-1:0] ra, rb;
    RST_N = 1'b0; START = 1'b0; A = '0; B = '0;
    LT_IN = 1'b0; EQ_IN = 1'b0; GT_IN = 1'b0;
    repeat (2) @(negedge CLK);
    #1 RST_N = 1'b1;
    checking = 1'b1;

    // Reset state
    checkOutput("rst_busy", int'(BUSY), 0);
    checkOutput("rst_done", int'(DONE), 0);
    checkOutput("rst_res",  int'({LT_OUT, EQ_OUT, GT_OUT}), 0);
    checkOutput("rst_bits", int'(BITS), 0);

    // Hand-computed cases
    runCase("eq_cascade",  8'hC0, 8'hC0, 1'b0, 1'b1, 1'b0, 3'b010, 8, 9);
    runCase("msb_lt",      8'h40, 8'hC0, 1'b0, 1'b0, 1'b0, 3'b100, 1, 2);
    runCase("mid_gt",      8'hF0, 8'hC0, 1'b0, 1'b0, 1'b0, 3'b001, 3, 4);
    runCase("casc_gt",     8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'b001, 8, 9);
    runCase("casc_lt",     8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'b100, 8, 9);
    runCase("casc_none",   8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'b010, 8, 9);
    runCase("casc_all",    8'h5A, 8'h5A, 1'b1, 1'b1, 1'b1, 3'b010, 8, 9);
    runCase("lsb_lt",      8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 3'b100, 8, 9);

    // START while busy and in the DONE cycle is ignored
    applyStimulus(8'hF0, 8'h70, 1'b0, 1'b0, 1'b0);
    A = 8'h50; B = 8'h80; START = 1'b1;
    checkOutput("b2b_busy", int'(BUSY), 1);
    @(negedge CLK); #1;
    checkOutput("b2b_done1", int'(DONE), 1);
    checkOutput("b2b_res1",  int'({LT_OUT, EQ_OUT, GT_OUT}), 3'b001);
    checkOutput("b2b_bits1", int'(BITS), 1);
    @(negedge CLK); #1;
    checkOutput("b2b_idle", int'(BUSY), 0);
    @(negedge CLK); #1;
    START = 1'b0;
    waitDone(lat, 1'b0);
    checkOutput("b2b_lat2",  lat, 2);
    checkOutput("b2b_res2",  int'({LT_OUT, EQ_OUT, GT_OUT}), 3'b100);
    checkOutput("b2b_bits2", int'(BITS), 1);

    // Reset in scan cycle 4 clears everything at once
    applyStimulus(8'hC0, 8'hC0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge CLK);
    #1 RST_N = 1'b0;
    #1;
    checkOutput("mid_rst_busy", int'(BUSY), 0);
    checkOutput("mid_rst_done", int'(DONE), 0);
    checkOutput("mid_rst_res",  int'({LT_OUT, EQ_OUT, GT_OUT}), 0);
    checkOutput("mid_rst_bits", int'(BITS), 0);
    @(negedge CLK); #1 RST_N = 1'b1;
    repeat (WIDTH + 2) @(negedge CLK);
    #1 checkOutput("mid_rst_nodone", int'(DONE), 0);
    runCase("after_rst", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 3'b001, 8, 9);

    // Randomized operands: fully random, equal, or differing at a chosen bit
    for (int n = 0; n < 60; n++) begin
      int mode;
      logic lt, eq, gt;
      mode = $urandom_range(0, 2);
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (mode == 1) rb = ra;
      if (mode == 2) rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH-1));
      {lt, eq, gt} = 3'($urandom);
      applyStimulus(ra, rb, lt, eq, gt);
      waitDone(lat, 1'b1);
      checkOutput("rand_lat", lat, expectBits(ra, rb) + 1);
      checkOutput("rand_res", int'({LT_OUT, EQ_OUT, GT_OUT}), int'(expectRes(ra, rb, lt, eq, gt)));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    @(negedge CLK); #1;
    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
